hook_launch_ctrl: RTL and testbench

Hook motion controller for the Gold Miner VGA game. It replaces the free-running hook animation and sits directly upstream of `drawcon`. It swings the hook direction back and forth, launches it on a player fire input, and extends it until it hits an object or reaches maximum length. It then retracts the hook, slower when carrying a heavy object. Each clock it drives the hook-tip pixel position that `drawcon` consumes as `blkpos_x` / `blkpos_y`.

---
 rtl/hook_launch_ctrl_if.sv | 25 ++
 rtl/hook_launch_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_hook_launch_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/hook_launch_ctrl_if.sv
// Signal bundle between the game logic and the hook motion controller:
// per-frame inputs toward the controller, hook-tip position and status back out.
interface hook_launch_ctrl_if;
    logic        frame_tick;
    logic        fire;
    logic        obj_hit;
    logic        obj_heavy;
    logic [10:0] hook_x;
    logic [9:0]  hook_y;
    logic [9:0]  hook_len;
    logic [3:0]  dir_idx;
    logic        busy;
    logic        loaded;
    logic        catch_done;

    modport master (
        output frame_tick, fire, obj_hit, obj_heavy,
        input  hook_x, hook_y, hook_len, dir_idx, busy, loaded, catch_done
    );

    modport slave (
        input  frame_tick, fire, obj_hit, obj_heavy,
        output hook_x, hook_y, hook_len, dir_idx, busy, loaded, catch_done
    );
endinterface

// File: rtl/hook_launch_ctrl.sv
// Gold Miner hook controller: swings the hook, launches on fire, extends until
// hit or max length, retracts (slower when heavy), and drives the tip pixel.
module hook_launch_ctrl #(
    parameter logic [10:0] PIVOT_X     = 11'd640,
    parameter logic [9:0]  PIVOT_Y     = 10'd120,
    parameter logic [9:0]  MAX_LEN     = 10'd400,
    parameter logic [9:0]  EXT_SPEED   = 10'd4,
    parameter logic [9:0]  RET_SPEED   = 10'd4,
    parameter logic [9:0]  HEAVY_SPEED = 10'd1,
    parameter logic [7:0]  SWING_DIV   = 8'd4
) (
    input logic               clk,
    input logic               rst,
    hook_launch_ctrl_if.slave hif
);

    typedef enum logic [1:0] {
        ST_SWING   = 2'd0,
        ST_EXTEND  = 2'd1,
        ST_RETRACT = 2'd2
    } state_t;

    localparam logic [7:0] SWING_LAST = SWING_DIV - 8'd1;

    // Direction table x component, 1/16 pixel per length pixel.
    function automatic logic signed [5:0] dx_lut(input logic [3:0] idx);
        logic signed [5:0] v;
        case (idx)
            4'd0:    v = -6'sd14;
            4'd1:    v = -6'sd11;
            4'd2:    v = -6'sd8;
            4'd3:    v = -6'sd4;
            4'd4:    v =  6'sd0;
            4'd5:    v =  6'sd4;
            4'd6:    v =  6'sd8;
            4'd7:    v =  6'sd11;
            4'd8:    v =  6'sd14;
            default: v =  6'sd0;
        endcase
        return v;
    endfunction

    // Direction table y component (always downward).
    function automatic logic [4:0] dy_lut(input logic [3:0] idx);
        logic [4:0] v;
        case (idx)
            4'd0:    v = 5'd8;
            4'd1:    v = 5'd11;
            4'd2:    v = 5'd14;
            4'd3:    v = 5'd15;
            4'd4:    v = 5'd16;
            4'd5:    v = 5'd15;
            4'd6:    v = 5'd14;
            4'd7:    v = 5'd11;
            4'd8:    v = 5'd8;
            default: v = 5'd16;
        endcase
        return v;
    endfunction

    state_t      state_q,      state_d;
    logic [9:0]  hook_len_q,   hook_len_d;
    logic [3:0]  dir_idx_q,    dir_idx_d;
    logic        dir_neg_q,    dir_neg_d;
    logic [7:0]  swing_cnt_q,  swing_cnt_d;
    logic        fire_q,       fire_d;
    logic        fire_armed_q, fire_armed_d;
    logic        heavy_q,      heavy_d;
    logic        loaded_q,     loaded_d;
    logic        busy_q,       busy_d;
    logic        catch_done_q, catch_done_d;
    logic [10:0] hook_x_q,     hook_x_d;
    logic [9:0]  hook_y_q,     hook_y_d;

    logic               launch_s;
    logic [9:0]         ret_speed_s;
    logic [10:0]        ext_sum_s;
    logic signed [15:0] dx_ext_s;
    logic signed [15:0] prod_x_s;
    logic signed [15:0] shr_x_s;
    logic [15:0]        prod_y_s;

    // Tip position from the current length and direction; registered below.
    always_comb begin
        dx_ext_s = 16'(dx_lut(dir_idx_q));
        prod_x_s = $signed({6'd0, hook_len_q}) * dx_ext_s;
        shr_x_s  = prod_x_s >>> 4;
        prod_y_s = {6'd0, hook_len_q} * {11'd0, dy_lut(dir_idx_q)};
        hook_x_d = PIVOT_X + shr_x_s[10:0];
        hook_y_d = PIVOT_Y + prod_y_s[13:4];
    end

    // Next-state logic for the swing / extend / retract sequence.
    always_comb begin
        state_d      = state_q;
        hook_len_d   = hook_len_q;
        dir_idx_d    = dir_idx_q;
        dir_neg_d    = dir_neg_q;
        swing_cnt_d  = swing_cnt_q;
        heavy_d      = heavy_q;
        loaded_d     = loaded_q;
        catch_done_d = 1'b0;
        fire_d       = hif.fire;
        // A fire held across reset must be released once before it can launch.
        fire_armed_d = fire_armed_q | ~hif.fire;
        launch_s     = hif.fire & ~fire_q & fire_armed_q;
        ret_speed_s  = (loaded_q & heavy_q) ? HEAVY_SPEED : RET_SPEED;
        ext_sum_s    = {1'b0, hook_len_q} + {1'b0, EXT_SPEED};

        case (state_q)
            ST_SWING: begin
                hook_len_d = 10'd0;
                if (launch_s) begin
                    state_d = ST_EXTEND;
                end else if (hif.frame_tick) begin
                    if (swing_cnt_q == SWING_LAST) begin
                        swing_cnt_d = 8'd0;
                        if (dir_idx_q == 4'd8) begin
                            dir_idx_d = 4'd7;
                            dir_neg_d = 1'b1;
                        end else if (dir_idx_q == 4'd0) begin
                            dir_idx_d = 4'd1;
                            dir_neg_d = 1'b0;
                        end else if (dir_neg_q) begin
                            dir_idx_d = dir_idx_q - 4'd1;
                        end else begin
                            dir_idx_d = dir_idx_q + 4'd1;
                        end
                    end else begin
                        swing_cnt_d = swing_cnt_q + 8'd1;
                    end
                end else begin
                    swing_cnt_d = swing_cnt_q;
                end
            end
            ST_EXTEND: begin
                if (hif.obj_hit) begin
                    state_d  = ST_RETRACT;
                    loaded_d = 1'b1;
                    heavy_d  = hif.obj_heavy;
                end else if (hif.frame_tick) begin
                    if (ext_sum_s >= {1'b0, MAX_LEN}) begin
                        hook_len_d = MAX_LEN;
                        state_d    = ST_RETRACT;
                        loaded_d   = 1'b0;
                        heavy_d    = 1'b0;
                    end else begin
                        hook_len_d = ext_sum_s[9:0];
                    end
                end else begin
                    hook_len_d = hook_len_q;
                end
            end
            ST_RETRACT: begin
                if (hif.frame_tick) begin
                    if (hook_len_q <= ret_speed_s) begin
                        hook_len_d   = 10'd0;
                        state_d      = ST_SWING;
                        swing_cnt_d  = 8'd0;
                        catch_done_d = loaded_q;
                        loaded_d     = 1'b0;
                        heavy_d      = 1'b0;
                    end else begin
                        hook_len_d = hook_len_q - ret_speed_s;
                    end
                end else begin
                    hook_len_d = hook_len_q;
                end
            end
            default: begin
                state_d    = ST_SWING;
                hook_len_d = 10'd0;
                loaded_d   = 1'b0;
                heavy_d    = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_SWING);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_SWING;
            hook_len_q   <= 10'd0;
            dir_idx_q    <= 4'd4;
            dir_neg_q    <= 1'b0;
            swing_cnt_q  <= 8'd0;
            fire_q       <= 1'b0;
            fire_armed_q <= 1'b0;
            heavy_q      <= 1'b0;
            loaded_q     <= 1'b0;
            busy_q       <= 1'b0;
            catch_done_q <= 1'b0;
            hook_x_q     <= PIVOT_X;
            hook_y_q     <= PIVOT_Y;
        end else begin
            state_q      <= state_d;
            hook_len_q   <= hook_len_d;
            dir_idx_q    <= dir_idx_d;
            dir_neg_q    <= dir_neg_d;
            swing_cnt_q  <= swing_cnt_d;
            fire_q       <= fire_d;
            fire_armed_q <= fire_armed_d;
            heavy_q      <= heavy_d;
            loaded_q     <= loaded_d;
            busy_q       <= busy_d;
            catch_done_q <= catch_done_d;
            hook_x_q     <= hook_x_d;
            hook_y_q     <= hook_y_d;
        end
    end

    assign hif.hook_x     = hook_x_q;
    assign hif.hook_y     = hook_y_q;
    assign hif.hook_len   = hook_len_q;
    assign hif.dir_idx    = dir_idx_q;
    assign hif.busy       = busy_q;
    assign hif.loaded     = loaded_q;
    assign hif.catch_done = catch_done_q;

endmodule

// File: tb/tb_hook_launch_ctrl.sv
// Directed bench for hook_launch_ctrl: swing, extend, angled tip, max length,
// heavy catch, hit on the max-length tick, and reset during a loaded retract.
module tb_hook_launch_ctrl;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   catch_cnt;
    int   catch_base;

    hook_launch_ctrl_if hif ();

    hook_launch_ctrl dut (
        .clk (clk),
        .rst (rst),
        .hif (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts catch_done pulses seen at clock edges.
    always @(posedge clk) begin
        if (hif.catch_done === 1'b1) catch_cnt <= catch_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            hif.frame_tick = 1'b1;
            @(negedge clk);
            hif.frame_tick = 1'b0;
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        catch_cnt = 0;
        rst = 1'b1;
        hif.frame_tick = 1'b0;
        hif.fire = 1'b0;
        hif.obj_hit = 1'b0;
        hif.obj_heavy = 1'b0;
        cyc(3);
        check("rst_dir", 32'(hif.dir_idx), 32'd4);
        check("rst_len", 32'(hif.hook_len), 32'd0);
        check("rst_x", 32'(hif.hook_x), 32'd640);
        check("rst_y", 32'(hif.hook_y), 32'd120);
        check("rst_busy", 32'(hif.busy), 32'd0);
        check("rst_loaded", 32'(hif.loaded), 32'd0);
        check("rst_catch", 32'(hif.catch_done), 32'd0);
        rst = 1'b0;
        cyc(2);

        // Swing sweep
        ticks(4);
        check("swing4_dir", 32'(hif.dir_idx), 32'd5);
        ticks(12);
        check("swing16_dir", 32'(hif.dir_idx), 32'd8);
        ticks(4);
        check("swing20_dir", 32'(hif.dir_idx), 32'd7);
        cyc(1);
        check("swing_x", 32'(hif.hook_x), 32'd640);
        check("swing_y", 32'(hif.hook_y), 32'd120);
        check("swing_len", 32'(hif.hook_len), 32'd0);
        ticks(12);
        check("swing32_dir", 32'(hif.dir_idx), 32'd4);

        // Straight extend with fire toggling
        hif.fire = 1'b1;
        cyc(1);
        check("launch_busy", 32'(hif.busy), 32'd1);
        hif.fire = 1'b0;
        cyc(1);
        hif.fire = 1'b1;
        cyc(1);
        hif.fire = 1'b0;
        ticks(10);
        cyc(1);
        check("ext_len", 32'(hif.hook_len), 32'd40);
        check("ext_x", 32'(hif.hook_x), 32'd640);
        check("ext_y", 32'(hif.hook_y), 32'd160);
        check("ext_busy", 32'(hif.busy), 32'd1);
        check("ext_dir", 32'(hif.dir_idx), 32'd4);

        // Heavy catch at length 40
        hif.obj_hit = 1'b1;
        hif.obj_heavy = 1'b1;
        cyc(1);
        hif.obj_hit = 1'b0;
        hif.obj_heavy = 1'b0;
        check("hit_loaded", 32'(hif.loaded), 32'd1);
        check("hit_len", 32'(hif.hook_len), 32'd40);
        catch_base = catch_cnt;
        ticks(39);
        check("heavy39_len", 32'(hif.hook_len), 32'd1);
        check("heavy39_busy", 32'(hif.busy), 32'd1);
        ticks(1);
        check("heavy40_len", 32'(hif.hook_len), 32'd0);
        check("heavy40_catch", 32'(hif.catch_done), 32'd1);
        check("heavy40_loaded", 32'(hif.loaded), 32'd0);
        check("heavy40_busy", 32'(hif.busy), 32'd0);
        cyc(1);
        check("catch_drop", 32'(hif.catch_done), 32'd0);
        cyc(1);
        check("catch_once", 32'(catch_cnt - catch_base), 32'd1);

        // Sweep down to 0, angled tip, then max length
        ticks(16);
        check("swing_to0", 32'(hif.dir_idx), 32'd0);
        hif.fire = 1'b1;
        cyc(1);
        hif.fire = 1'b0;
        check("launch0_busy", 32'(hif.busy), 32'd1);
        ticks(25);
        cyc(1);
        check("d0_len", 32'(hif.hook_len), 32'd100);
        check("d0_x", 32'(hif.hook_x), 32'd552);
        check("d0_y", 32'(hif.hook_y), 32'd170);
        ticks(75);
        check("max_len", 32'(hif.hook_len), 32'd400);
        check("max_loaded", 32'(hif.loaded), 32'd0);
        check("max_busy", 32'(hif.busy), 32'd1);
        cyc(1);
        check("max_x", 32'(hif.hook_x), 32'd290);
        check("max_y", 32'(hif.hook_y), 32'd320);
        catch_base = catch_cnt;
        ticks(99);
        check("ret99_len", 32'(hif.hook_len), 32'd4);
        check("ret99_busy", 32'(hif.busy), 32'd1);
        ticks(1);
        check("ret100_len", 32'(hif.hook_len), 32'd0);
        check("ret100_busy", 32'(hif.busy), 32'd0);
        cyc(2);
        check("empty_no_catch", 32'(catch_cnt - catch_base), 32'd0);

        // Sweep up to 8, angled tip, hit on the max-length tick
        ticks(32);
        check("swing_to8", 32'(hif.dir_idx), 32'd8);
        hif.fire = 1'b1;
        cyc(1);
        hif.fire = 1'b0;
        ticks(25);
        cyc(1);
        check("d8_x", 32'(hif.hook_x), 32'd727);
        check("d8_y", 32'(hif.hook_y), 32'd170);
        ticks(74);
        check("pre_max_len", 32'(hif.hook_len), 32'd396);
        hif.frame_tick = 1'b1;
        hif.obj_hit = 1'b1;
        cyc(1);
        hif.frame_tick = 1'b0;
        hif.obj_hit = 1'b0;
        check("coin_loaded", 32'(hif.loaded), 32'd1);
        check("coin_len", 32'(hif.hook_len), 32'd396);
        ticks(10);
        check("light_ret_len", 32'(hif.hook_len), 32'd356);

        // Asynchronous reset mid-retract while loaded, fire held
        hif.fire = 1'b1;
        catch_base = catch_cnt;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_len", 32'(hif.hook_len), 32'd0);
        check("arst_loaded", 32'(hif.loaded), 32'd0);
        check("arst_busy", 32'(hif.busy), 32'd0);
        check("arst_catch", 32'(hif.catch_done), 32'd0);
        check("arst_x", 32'(hif.hook_x), 32'd640);
        check("arst_y", 32'(hif.hook_y), 32'd120);
        check("arst_dir", 32'(hif.dir_idx), 32'd4);
        @(negedge clk);
        rst = 1'b0;
        cyc(5);
        check("held_fire_idle", 32'(hif.busy), 32'd0);
        hif.fire = 1'b0;
        cyc(1);
        hif.fire = 1'b1;
        cyc(1);
        check("refire_busy", 32'(hif.busy), 32'd1);
        check("arst_no_catch", 32'(catch_cnt - catch_base), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
